// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-side AXI bus master.
// Holds the master FSM state encoding, the latched request payload and the
// AXI encodings used on the read and write channels.
package dbus_pkg;

  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned STRB_W           = DATA_W / 8;
  localparam int unsigned AXI_LEN_W        = 8;
  localparam int unsigned WORD_OFFSET_BITS = 2;
  localparam int unsigned LINE_BEATS       = 4;
  localparam int unsigned LINE_OFFSET_BITS = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AWW,
    ST_B,
    ST_DONE
  } dbus_state_e;

  // Request captured on acceptance; stays stable for the whole transaction.
  typedef struct packed {
    logic [ADDR_W-1:WORD_OFFSET_BITS] addr;
    logic [DATA_W-1:0]                data;
    logic [STRB_W-1:0]                be_n;
  } dbus_req_t;

endpackage

// File: rtl/dbus_aw_w_join.sv
// Joins the AW and W channels of a single-beat write.
// A start pulse raises both VALIDs; each VALID drops after its own handshake,
// and both_done_o pulses in the cycle the second (or both) handshakes occur.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       begin a new write (one-cycle pulse)
//   awready_i     AWREADY from the interconnect
//   wready_i      WREADY from the interconnect
//   awvalid_o     AWVALID to the interconnect
//   wvalid_o      WVALID to the interconnect
//   both_done_o   both handshakes complete this cycle (combinational)
module dbus_aw_w_join (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic awready_i,
  input  logic wready_i,
  output logic awvalid_o,
  output logic wvalid_o,
  output logic both_done_o
);

  logic active_q, active_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic aw_hs, w_hs;

  // Handshake tracking and completion detection.
  always_comb begin
    awvalid_o   = active_q & ~aw_done_q;
    wvalid_o    = active_q & ~w_done_q;
    aw_hs       = awvalid_o & awready_i;
    w_hs        = wvalid_o & wready_i;
    both_done_o = active_q & (aw_done_q | aw_hs) & (w_done_q | w_hs);
    active_d    = active_q;
    aw_done_d   = aw_done_q | aw_hs;
    w_done_d    = w_done_q | w_hs;
    if (both_done_o) begin
      active_d  = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
    if (start_i) begin
      active_d  = 1'b1;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      active_q  <= active_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: rtl/dcache_axi_master.sv
// Data-cache AXI4 master (port M1).
// Line refills become 4-beat INCR read bursts streamed back one word per
// cycle; write-through stores become single-beat writes.
// Optional feature macro: DBUS_POSTED_WRITE_EN -- stores complete once AW and
// W are accepted, BREADY is held high, and a single outstanding B response is
// tracked so the next request waits for it.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   D_req/D_write/D_addr     cache request handshake, direction, byte address
//   D_in/D_type              store data, active-low byte enables
//   D_out/rvalid_o           read beat data and its valid strobe (pass-through)
//   D_wait                   transaction in progress
//   err_o                    sticky bus error (cleared only by rst)
//   AR*/R*/AW*/W*/B*         AXI4 master channels
module dcache_axi_master
  import dbus_pkg::*;
#(
  parameter int unsigned     ID_W = 4,
  parameter logic [ID_W-1:0] M_ID = ID_W'(1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 D_req,
  input  logic                 D_write,
  input  logic [ADDR_W-1:0]    D_addr,
  input  logic [DATA_W-1:0]    D_in,
  input  logic [STRB_W-1:0]    D_type,
  output logic [DATA_W-1:0]    D_out,
  output logic                 rvalid_o,
  output logic                 D_wait,
  output logic                 err_o,
  output logic [ID_W-1:0]      ARID,
  output logic [ADDR_W-1:0]    ARADDR,
  output logic [AXI_LEN_W-1:0] ARLEN,
  output logic [2:0]           ARSIZE,
  output logic [1:0]           ARBURST,
  output logic                 ARVALID,
  input  logic                 ARREADY,
  input  logic [ID_W-1:0]      RID,
  input  logic [DATA_W-1:0]    RDATA,
  input  logic [1:0]           RRESP,
  input  logic                 RLAST,
  input  logic                 RVALID,
  output logic                 RREADY,
  output logic [ID_W-1:0]      AWID,
  output logic [ADDR_W-1:0]    AWADDR,
  output logic [AXI_LEN_W-1:0] AWLEN,
  output logic [2:0]           AWSIZE,
  output logic [1:0]           AWBURST,
  output logic                 AWVALID,
  input  logic                 AWREADY,
  output logic [DATA_W-1:0]    WDATA,
  output logic [STRB_W-1:0]    WSTRB,
  output logic                 WLAST,
  output logic                 WVALID,
  input  logic                 WREADY,
  input  logic [ID_W-1:0]      BID,
  input  logic [1:0]           BRESP,
  input  logic                 BVALID,
  output logic                 BREADY
);

  dbus_state_e state_q, state_d;
  dbus_req_t   req_q, req_d;
  logic        err_q, err_d;
  logic        join_start;
  logic        join_done;
  logic        req_block;
  logic        r_bad;
  logic        b_bad;

  // Byte offset within the word is not needed: reads fetch a line, writes use strobes.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^D_addr[WORD_OFFSET_BITS-1:0];

  // Any non-OKAY response or foreign ID is reported through the sticky flag.
  assign r_bad = (RRESP != AXI_RESP_OKAY) || (RID != M_ID);
  assign b_bad = (BRESP != AXI_RESP_OKAY) || (BID != M_ID);

`ifdef DBUS_POSTED_WRITE_EN
  logic b_pending_q, b_pending_d;
  // A new request must not start while a posted write is still unacknowledged.
  assign req_block = b_pending_q & ~BVALID;
`else
  assign req_block = 1'b0;
`endif

  // Fixed AXI attributes and payload driven from the latched request.
  assign ARID    = M_ID;
  assign ARADDR  = {req_q.addr[ADDR_W-1:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
  assign ARLEN   = AXI_LEN_W'(LINE_BEATS - 1);
  assign ARSIZE  = AXI_SIZE_WORD;
  assign ARBURST = AXI_BURST_INCR;
  assign AWID    = M_ID;
  assign AWADDR  = {req_q.addr, WORD_OFFSET_BITS'(0)};
  assign AWLEN   = AXI_LEN_W'(0);
  assign AWSIZE  = AXI_SIZE_WORD;
  assign AWBURST = AXI_BURST_INCR;
  assign WDATA   = req_q.data;
  assign WSTRB   = ~req_q.be_n;
  assign WLAST   = 1'b1;
  assign err_o   = err_q;

  dbus_aw_w_join u_aw_w_join (
    .clk         (clk),
    .rst         (rst),
    .start_i     (join_start),
    .awready_i   (AWREADY),
    .wready_i    (WREADY),
    .awvalid_o   (AWVALID),
    .wvalid_o    (WVALID),
    .both_done_o (join_done)
  );

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    err_d      = err_q;
    join_start = 1'b0;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    rvalid_o   = 1'b0;
    D_out      = '0;
    D_wait     = 1'b0;
`ifdef DBUS_POSTED_WRITE_EN
    BREADY      = 1'b1;
    b_pending_d = b_pending_q & ~BVALID;
    if (BVALID && b_bad) begin
      err_d = 1'b1;
    end
`else
    BREADY = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        D_wait = D_req;
        if (D_req && !req_block) begin
          req_d.addr = D_addr[ADDR_W-1:WORD_OFFSET_BITS];
          req_d.data = D_in;
          req_d.be_n = D_type;
          if (D_write) begin
            state_d    = ST_AWW;
            join_start = 1'b1;
          end else begin
            state_d = ST_AR;
          end
        end
      end

      ST_AR: begin
        D_wait  = 1'b1;
        ARVALID = 1'b1;
        if (ARREADY) begin
          state_d = ST_R;
        end
      end

      // Beats pass straight through; RLAST alone ends the burst.
      ST_R: begin
        D_wait   = 1'b1;
        RREADY   = 1'b1;
        rvalid_o = RVALID;
        if (RVALID) begin
          D_out = RDATA;
          if (r_bad) begin
            err_d = 1'b1;
          end
          if (RLAST) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_AWW: begin
        D_wait = 1'b1;
        if (join_done) begin
`ifdef DBUS_POSTED_WRITE_EN
          state_d     = ST_DONE;
          b_pending_d = 1'b1;
`else
          state_d = ST_B;
`endif
        end
      end

`ifndef DBUS_POSTED_WRITE_EN
      ST_B: begin
        D_wait = 1'b1;
        BREADY = 1'b1;
        if (BVALID) begin
          if (b_bad) begin
            err_d = 1'b1;
          end
          state_d = ST_DONE;
        end
      end
`endif

      // One idle cycle lets the requester drop D_req before the next accept.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

`ifdef DBUS_POSTED_WRITE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      b_pending_q <= 1'b0;
    end else begin
      b_pending_q <= b_pending_d;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_axi_master.sv
// Scoreboard bench for dcache_axi_master: stimulus pushes expected AR/AW/W
// transfers and read words into queues; a monitor pops and compares them as
// the DUT presents them. A small AXI slave answers with per-test delays.
module tb_dcache_axi_master;

  localparam logic [3:0] M_ID = 4'd1;
`ifdef DBUS_POSTED_WRITE_EN
  localparam int    W_ADJ       = 1;
  localparam logic  BREADY_RST  = 1'b1;
`else
  localparam int    W_ADJ       = 0;
  localparam logic  BREADY_RST  = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        D_req, D_write;
  logic [31:0] D_addr, D_in, D_out;
  logic [3:0]  D_type;
  logic        rvalid_o, D_wait, err_o;
  logic [3:0]  ARID, RID, AWID, BID;
  logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
  logic [7:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [3:0]  WSTRB;

  dcache_axi_master #(.ID_W(4), .M_ID(M_ID)) dut (
    .clk(clk), .rst(rst), .D_req(D_req), .D_write(D_write), .D_addr(D_addr),
    .D_in(D_in), .D_type(D_type), .D_out(D_out), .rvalid_o(rvalid_o),
    .D_wait(D_wait), .err_o(err_o),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Scoreboard queues
  logic [31:0] exp_ar[$];
  logic [31:0] exp_aw[$];
  logic [36:0] exp_w[$];
  logic [31:0] exp_rd[$];

  // Slave state and knobs
  r_beat_t rq[$];
  int ar_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [1:0] b_resp = 2'b00;
  int ar_w = 0, aw_w = 0, w_w = 0, b_w = 0, aw_pend = 0, w_pend = 0;
  bit s_r_hs = 0, s_aw_hs = 0, s_w_hs = 0, s_b_hs = 0;

  initial begin
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0; RLAST = 0; RID = M_ID;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0; BID = M_ID;
    forever begin
      @(posedge clk); #1;
      if (s_r_hs && rq.size() > 0) void'(rq.pop_front());
      if (s_aw_hs) aw_pend++;
      if (s_w_hs) w_pend++;
      if (s_b_hs) BVALID = 0;
      ARREADY = 0;
      if (ARVALID) begin
        if (ar_w >= ar_delay) begin ARREADY = 1; ar_w = 0; end
        else ar_w++;
      end
      if (RREADY && rq.size() > 0) begin
        RVALID = 1; RDATA = rq[0].data; RRESP = rq[0].resp; RLAST = (rq.size() == 1);
      end else begin
        RVALID = 0; RLAST = 0;
      end
      AWREADY = 0;
      if (AWVALID) begin
        if (aw_w >= aw_delay) begin AWREADY = 1; aw_w = 0; end
        else aw_w++;
      end
      WREADY = 0;
      if (WVALID) begin
        if (w_w >= w_delay) begin WREADY = 1; w_w = 0; end
        else w_w++;
      end
      if (!BVALID && aw_pend > 0 && w_pend > 0) begin
        if (b_w >= b_delay) begin
          BVALID = 1; BRESP = b_resp; aw_pend--; w_pend--; b_w = 0;
        end else b_w++;
      end
      s_r_hs  = RVALID && RREADY;
      s_aw_hs = AWVALID && AWREADY;
      s_w_hs  = WVALID && WREADY;
      s_b_hs  = BVALID && BREADY;
    end
  end

  // Monitor
  int  aw_cnt = 0, w_cnt = 0, b_hs_cyc = -10, ar_rise_cyc = -10;
  bit  m_aw_prev = 0, m_w_prev = 0, m_ar_prev = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (m_aw_prev) check("aw_valid_drop", 64'(AWVALID), 64'(0));
      if (m_w_prev) check("w_valid_drop", 64'(WVALID), 64'(0));
      if (ARVALID && !m_ar_prev) ar_rise_cyc = cyc;
      m_ar_prev = ARVALID;
      if (ARVALID && ARREADY) begin
        check("ar_expected", 64'(exp_ar.size() != 0), 64'(1));
        if (exp_ar.size() != 0) begin
          check("araddr", 64'(ARADDR), 64'(exp_ar.pop_front()));
          check("ar_attr", 64'({ARID, ARLEN, ARSIZE, ARBURST}), 64'({4'd1, 8'd3, 3'd2, 2'd1}));
        end
      end
      if (rvalid_o) begin
        check("rd_expected", 64'(exp_rd.size() != 0), 64'(1));
        if (exp_rd.size() != 0) check("rdata", 64'(D_out), 64'(exp_rd.pop_front()));
      end
      m_aw_prev = AWVALID && AWREADY;
      m_w_prev  = WVALID && WREADY;
      if (AWVALID && AWREADY) begin
        aw_cnt++;
        check("aw_expected", 64'(exp_aw.size() != 0), 64'(1));
        if (exp_aw.size() != 0) begin
          check("awaddr", 64'(AWADDR), 64'(exp_aw.pop_front()));
          check("aw_attr", 64'({AWID, AWLEN, AWSIZE, AWBURST}), 64'({4'd1, 8'd0, 3'd2, 2'd1}));
        end
      end
      if (WVALID && WREADY) begin
        w_cnt++;
        check("w_expected", 64'(exp_w.size() != 0), 64'(1));
        if (exp_w.size() != 0) check("wdata_strb_last", 64'({WDATA, WSTRB, WLAST}), 64'(exp_w.pop_front()));
      end
      if (BVALID && BREADY) b_hs_cyc = cyc;
    end
  end

  int last_done_cyc = 0;

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] typ, input int lat, input string name);
    int start;
    bit done;
    done = 0;
    @(posedge clk); #1;
    D_req = 1; D_write = wr; D_addr = addr; D_in = data; D_type = typ;
    start = cyc;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!D_wait) done = 1;
    end
    D_req = 0;
    last_done_cyc = cyc;
    check({name, "_latency"}, 64'(done ? (cyc - start) : -1), 64'(lat));
  endtask

  task automatic refill(input logic [31:0] addr, input logic [31:0] exp_araddr,
                        input logic [31:0] base, input int err_beat, input int lat,
                        input string name);
    r_beat_t b;
    exp_ar.push_back(exp_araddr);
    for (int i = 0; i < 4; i++) begin
      b.data = base + 32'(i);
      b.resp = (i == err_beat) ? 2'b10 : 2'b00;
      rq.push_back(b);
      exp_rd.push_back(base + 32'(i));
    end
    do_req(1'b0, addr, 32'h0, 4'hF, lat, name);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] typ,
                       input logic [31:0] exp_awaddr, input logic [3:0] exp_strb,
                       input int lat, input string name);
    exp_aw.push_back(exp_awaddr);
    exp_w.push_back({data, exp_strb, 1'b1});
    do_req(1'b1, addr, data, typ, lat, name);
  endtask

  initial begin
    int a0, w0;
    bit seen;
    r_beat_t b;
    rst = 1; D_req = 0; D_write = 0; D_addr = '0; D_in = '0; D_type = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valids", 64'({ARVALID, AWVALID, WVALID, RREADY, D_wait, rvalid_o, err_o}), 64'(0));
    check("rst_dout", 64'(D_out), 64'(0));
    check("rst_bready", 64'(BREADY), 64'(BREADY_RST));
    @(posedge clk); #1 rst = 0;

    refill(32'h0000_1234, 32'h0000_1230, 32'h0000_00A0, -1, 6, "refill0");
    store(32'h0000_2006, 32'hDEAD_BEEF, 4'b0011, 32'h0000_2004, 4'b1100, 3 - W_ADJ, "store0");
`ifndef DBUS_POSTED_WRITE_EN
    check("store0_done_after_b", 64'(last_done_cyc), 64'(b_hs_cyc + 1));
`endif

    aw_delay = 3; w_delay = 0; a0 = aw_cnt; w0 = w_cnt;
    store(32'h0000_3000, 32'h1111_2222, 4'b0000, 32'h0000_3000, 4'b1111, 6 - W_ADJ, "aw_late");
    check("aw_late_aw_xfers", 64'(aw_cnt - a0), 64'(1));
    check("aw_late_w_xfers", 64'(w_cnt - w0), 64'(1));
    aw_delay = 0; w_delay = 3; a0 = aw_cnt; w0 = w_cnt;
    store(32'h0000_300B, 32'h3333_4444, 4'b1010, 32'h0000_3008, 4'b0101, 6 - W_ADJ, "w_late");
    check("w_late_aw_xfers", 64'(aw_cnt - a0), 64'(1));
    check("w_late_w_xfers", 64'(w_cnt - w0), 64'(1));
    w_delay = 0;

    check("err_before", 64'(err_o), 64'(0));
    refill(32'h0000_0040, 32'h0000_0040, 32'h0000_00C0, 2, 6, "refill_slverr");
    check("err_after_slverr", 64'(err_o), 64'(1));
    store(32'h0000_0100, 32'hCAFE_F00D, 4'b1110, 32'h0000_0100, 4'b0001, 3 - W_ADJ, "store_err");
    check("err_sticky", 64'(err_o), 64'(1));

    // Reset in the middle of a burst
    exp_ar.push_back(32'h0000_0080);
    for (int i = 0; i < 4; i++) begin
      b.data = 32'h0000_00D0 + 32'(i);
      b.resp = 2'b00;
      rq.push_back(b);
    end
    exp_rd.push_back(32'h0000_00D0);
    exp_rd.push_back(32'h0000_00D1);
    @(posedge clk); #1;
    D_req = 1; D_write = 0; D_addr = 32'h0000_0088;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rvalid_o) seen = 1;
    end
    check("rst_test_beat0_seen", 64'(seen), 64'(1));
    @(posedge clk); #1;
    rst = 1; D_req = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_outputs", 64'({ARVALID, RREADY, D_wait, rvalid_o, AWVALID, WVALID}), 64'(0));
    check("rst_mid_err", 64'(err_o), 64'(0));
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    rq.delete();
    refill(32'h0000_0500, 32'h0000_0500, 32'h0000_00E0, -1, 6, "refill_after_rst");

`ifdef DBUS_POSTED_WRITE_EN
    b_delay = 5;
    store(32'h0000_4000, 32'h5555_6666, 4'b0000, 32'h0000_4000, 4'b1111, 2, "posted_store");
    refill(32'h0000_5010, 32'h0000_5010, 32'h0000_00F0, -1, 10, "refill_after_posted");
    check("ar_after_bvalid", 64'(ar_rise_cyc), 64'(b_hs_cyc + 1));
    b_delay = 0;
`endif

    repeat (3) @(negedge clk);
    check("exp_ar_drained", 64'(exp_ar.size()), 64'(0));
    check("exp_rd_drained", 64'(exp_rd.size()), 64'(0));
    check("exp_aw_drained", 64'(exp_aw.size()), 64'(0));
    check("exp_w_drained", 64'(exp_w.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
